// File: rtl/rv_alu_seq.sv
// Issue/sequencing controller in front of rv_alu: registers one op per handshake,
// counts its class latency and returns the selected ALU result with its rd tag.

package rv_alu_seq_pkg;
    localparam int unsigned ALU_W = 5;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
        ALU_REM, ALU_REMU, ALU_FADD, ALU_FSUB, ALU_FDIV
    } alu_t;
endpackage

module rv_alu_seq
    import rv_alu_seq_pkg::*;
#(
    parameter int unsigned LAT_MUL  = 1,
    parameter int unsigned LAT_FADD = 1,
    parameter int unsigned LAT_DIV  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic        i_valid,
    output logic        i_ready,
    input  alu_t        i_alu,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [4:0]  i_rd,
    input  logic        flush,
    output alu_t        alu,
    output logic [31:0] rrd1,
    output logic [31:0] rrd2,
    input  logic [31:0] rwdat,
    input  logic [31:0] rwdatx,
    output logic        o_valid,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data,
    output logic        busy,
    output logic [31:0] stall_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;

    typedef enum logic {S_IDLE, S_EX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_x_q, sel_x_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    alu_t                alu_d;
    logic [DATA_W-1:0]   rrd1_d, rrd2_d;
    logic                o_valid_d;
    logic [TAG_W-1:0]    o_rd_d;
    logic [DATA_W-1:0]   o_data_d;
    logic [DATA_W-1:0]   stall_cnt_d;
    logic                busy_d;
    logic                final_c;
    logic                accept_c;

    // Extra EX cycles for each op class beyond the single-cycle path.
    function automatic logic [CNT_W-1:0] op_lat(input alu_t op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU:       op_lat = CNT_W'(LAT_MUL);
            ALU_FADD, ALU_FSUB:                            op_lat = CNT_W'(LAT_FADD);
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_FDIV: op_lat = CNT_W'(LAT_DIV);
            default:                                       op_lat = '0;
        endcase
    endfunction

    function automatic logic op_is_mul(input alu_t op);
        case (op)
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: op_is_mul = 1'b1;
            default:                                  op_is_mul = 1'b0;
        endcase
    endfunction

    assign final_c  = (state_q == S_EX) && (cnt_q == '0);
    assign i_ready  = !flush && ((state_q == S_IDLE) || final_c);
    assign accept_c = i_valid && i_ready;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_x_d     = sel_x_q;
        tag_d       = tag_q;
        alu_d       = alu;
        rrd1_d      = rrd1;
        rrd2_d      = rrd2;
        o_valid_d   = 1'b0;
        o_rd_d      = o_rd;
        o_data_d    = o_data;
        stall_cnt_d = stall_cnt;

        if (i_valid && !i_ready && (stall_cnt != '1)) begin
            stall_cnt_d = stall_cnt + DATA_W'(1);
        end

        case (state_q)
            S_IDLE: ;
            S_EX: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    o_valid_d = 1'b1;
                    o_rd_d    = tag_q;
                    o_data_d  = sel_x_q ? rwdatx : rwdat;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new op in the final cycle keeps the controller in EX back-to-back.
        if (accept_c) begin
            state_d = S_EX;
            cnt_d   = op_lat(i_alu);
            sel_x_d = op_is_mul(i_alu);
            tag_d   = i_rd;
            alu_d   = i_alu;
            rrd1_d  = i_rs1;
            rrd2_d  = i_rs2;
        end

        busy_d = (state_d == S_EX);
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_x_q   <= 1'b0;
            tag_q     <= '0;
            alu       <= ALU_ADD;
            rrd1      <= '0;
            rrd2      <= '0;
            o_valid   <= 1'b0;
            o_rd      <= '0;
            o_data    <= '0;
            stall_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_x_q   <= sel_x_d;
            tag_q     <= tag_d;
            alu       <= alu_d;
            rrd1      <= rrd1_d;
            rrd2      <= rrd2_d;
            o_valid   <= o_valid_d;
            o_rd      <= o_rd_d;
            o_data    <= o_data_d;
            stall_cnt <= stall_cnt_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rv_alu_seq.sv
// Bench for rv_alu_seq: directed scenarios plus random issue, scored against a
// cycle-indexed queue of expected completions.

module tb_rv_alu_seq;
    import rv_alu_seq_pkg::*;

    logic        clk;
    logic        xreset;
    logic        i_valid;
    logic        i_ready;
    alu_t        i_alu;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_rd;
    logic        flush;
    alu_t        alu;
    logic [31:0] rrd1;
    logic [31:0] rrd2;
    logic [31:0] rwdat;
    logic [31:0] rwdatx;
    logic        o_valid;
    logic [4:0]  o_rd;
    logic [31:0] o_data;
    logic        busy;
    logic [31:0] stall_cnt;

    rv_alu_seq dut (
        .clk(clk), .xreset(xreset), .i_valid(i_valid), .i_ready(i_ready),
        .i_alu(i_alu), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .flush(flush),
        .alu(alu), .rrd1(rrd1), .rrd2(rrd2), .rwdat(rwdat), .rwdatx(rwdatx),
        .o_valid(o_valid), .o_rd(o_rd), .o_data(o_data), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc;
    int          busy_until;
    logic [31:0] m_stall;
    logic [31:0] seen [32];
    int          tests;
    int          fails;

    // RISC-V result rules; F-ops use integer stand-ins for this stub ALU.
    function automatic logic [31:0] alu_ref(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (op)
            ALU_ADD, ALU_FADD: return a + b;
            ALU_SUB, ALU_FSUB: return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return 32'(sa < sb);
            ALU_SLTU: return 32'(a < b);
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            ALU_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            ALU_DIVU, ALU_FDIV: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic is_mul(input alu_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic int lat_of(input alu_t op);
        if (is_mul(op)) return 1;
        if (op inside {ALU_FADD, ALU_FSUB}) return 1;
        if (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_FDIV}) return 16;
        return 0;
    endfunction

    // Stub rv_alu: the wrong port carries the inverted result so a bad select shows.
    always_comb rwdat = is_mul(alu) ? ~alu_ref(alu, rrd1, rrd2) : alu_ref(alu, rrd1, rrd2);
    always_ff @(posedge clk) rwdatx <= is_mul(alu) ? alu_ref(alu, rrd1, rrd2) : ~alu_ref(alu, rrd1, rrd2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of stimulus; outputs checked on the falling edge.
    task automatic step(input logic v, input alu_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic fl);
        logic exp_ready;
        int   lat;
        i_valid = v; i_alu = op; i_rs1 = a; i_rs2 = b; i_rd = rd; flush = fl;
        @(negedge clk);
        exp_ready = !fl && (cyc >= busy_until);
        check("i_ready", 32'(i_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(cyc <= busy_until));
        check("stall_cnt", stall_cnt, m_stall);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("o_valid", 32'(o_valid), 32'd1);
            check("o_rd", 32'(o_rd), 32'(exp_q[0].rd));
            check("o_data", o_data, exp_q[0].data);
            seen[o_rd] = o_data;
            void'(exp_q.pop_front());
        end else begin
            check("o_valid", 32'(o_valid), 32'd0);
        end
        if (v && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            exp_q.delete();
            if (busy_until > cyc) busy_until = cyc;
        end
        if (v && exp_ready) begin
            lat = lat_of(op);
            exp_q.push_back('{cyc + 2 + lat, rd, alu_ref(op, a, b)});
            busy_until = cyc + 1 + lat;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_o_rd"}, 32'(o_rd), 32'd0);
        check({tag, "_o_data"}, o_data, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_stall"}, stall_cnt, 32'd0);
        check({tag, "_alu"}, 32'(alu), 32'(ALU_ADD));
        check({tag, "_rrd1"}, rrd1, 32'd0);
        check({tag, "_rrd2"}, rrd2, 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy_until = -1;
        m_stall    = 32'd0;
    endtask

    logic [31:0] s0;

    initial begin
        tests = 0; fails = 0; cyc = 0;
        for (int i = 0; i < 32; i++) seen[i] = 32'hA5A5_A5A5;
        model_reset();
        xreset = 1'b0; i_valid = 1'b0; i_alu = ALU_ADD; i_rs1 = '0; i_rs2 = '0; i_rd = '0; flush = 1'b0;
        #12;
        check_reset_vals("rst");
        check("rst_i_ready", 32'(i_ready), 32'd1);
        @(posedge clk); #1;
        xreset = 1'b1;

        // Back-to-back single-cycle ops.
        s0 = stall_cnt;
        step(1'b1, ALU_ADD, 32'd3, 32'd4, 5'd5, 1'b0);
        step(1'b1, ALU_SUB, 32'd10, 32'd3, 5'd6, 1'b0);
        idle(3);
        check("b2b_rd5", seen[5], 32'd7);
        check("b2b_rd6", seen[6], 32'd7);
        check("b2b_stall", stall_cnt - s0, 32'd0);

        // MUL low word taken from the delayed port, following ADD stalls once.
        s0 = stall_cnt;
        step(1'b1, ALU_MUL, 32'h0001_0000, 32'h0001_0000, 5'd7, 1'b0);
        step(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd8, 1'b0);
        step(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd8, 1'b0);
        idle(3);
        check("mul_data", seen[7], 32'd0);
        check("mul_add", seen[8], 32'd3);
        check("mul_stall", stall_cnt - s0, 32'd1);

        // DIVU latency with issue held high behind it.
        s0 = stall_cnt;
        step(1'b1, ALU_DIVU, 32'd100, 32'd7, 5'd9, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, ALU_ADD, 32'd5, 32'd5, 5'd10, 1'b0);
        idle(3);
        check("div_data", seen[9], 32'd14);
        check("div_stall", stall_cnt - s0, 32'd16);

        // Flush cancels an in-flight REM.
        step(1'b1, ALU_REM, 32'd100, 32'd7, 5'd11, 1'b0);
        idle(4);
        step(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
        step(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd12, 1'b0);
        idle(3);
        check("flush_none", seen[11], 32'hA5A5_A5A5);
        check("flush_next", seen[12], 32'd2);

        // Issue coinciding with flush in IDLE is refused.
        s0 = stall_cnt;
        step(1'b1, ALU_ADD, 32'd4, 32'd4, 5'd13, 1'b1);
        step(1'b1, ALU_ADD, 32'd4, 32'd4, 5'd13, 1'b0);
        idle(3);
        check("flissue_stall", stall_cnt - s0, 32'd1);
        check("flissue_data", seen[13], 32'd8);

        // Asynchronous reset in the middle of an FADD.
        seen[14] = 32'hA5A5_A5A5;
        step(1'b1, ALU_FADD, 32'd5, 32'd6, 5'd14, 1'b0);
        i_valid = 1'b0;
        xreset  = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        @(posedge clk); #1;
        xreset = 1'b1;
        model_reset();
        idle(4);
        check("mid_rst_none", seen[14], 32'hA5A5_A5A5);
        step(1'b1, ALU_ADD, 32'd2, 32'd2, 5'd15, 1'b0);
        idle(2);
        check("mid_rst_resume", seen[15], 32'd4);

        // Random issue, operand churn while stalled, occasional flush.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7,
                 alu_t'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                 5'($urandom),
                 $urandom_range(0, 31) == 0);
        end
        idle(20);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_alu_seq.md
Name: rv_alu_seq

Overview:
- Issue/sequencing controller between the decode/issue stage and rv_alu.
- Accepts one ALU operation per handshake, registers its operands, and drives them to the ALU.
- Counts the op-class latency (single, MUL +1, FADD/FSUB, DIV/REM/FDIV) and captures the correct ALU result port (rwdat or rwdatx).
- Returns the result with its rd tag and backpressures issue while a multi-cycle op is in flight.

Parameters:
- LAT_MUL, 1, extra cycles for MUL/MULH/MULHSU/MULHU; result taken from rwdatx.
- LAT_FADD, 1, extra cycles for FADD/FSUB.
- LAT_DIV, 16, extra cycles for DIV/DIVU/REM/REMU/FDIV.
- CNT_W, 5, width of the latency counter; must hold LAT_DIV.

Ports:
- clk  in  1  clock.
- xreset  in  1  asynchronous reset, active low.
- i_valid  in  1  issue request.
- i_ready  out  1  issue accept; a transfer happens when i_valid&&i_ready.
- i_alu  in  alu_t  operation code.
- i_rs1  in  32  operand 1.
- i_rs2  in  32  operand 2.
- i_rd  in  5  destination tag.
- flush  in  1  cancel the in-flight op and block issue this cycle.
- alu  out  alu_t  to rv_alu.alu.
- rrd1  out  32  to rv_alu.rrd1.
- rrd2  out  32  to rv_alu.rrd2.
- rwdat  in  32  from rv_alu, combinational result.
- rwdatx  in  32  from rv_alu, +1-latency multiply result.
- o_valid  out  1  one-cycle result strobe.
- o_rd  out  5  result tag.
- o_data  out  32  result value.
- busy  out  1  an op is in flight (state EX).
- stall_cnt  out  32  saturating count of cycles with i_valid && !i_ready.

Behaviour:
- Reset values (asynchronous, xreset=0):
  - state=IDLE, cnt=0.
  - alu=ADD, rrd1=0, rrd2=0.
  - o_valid=0, o_rd=0, o_data=0.
  - stall_cnt=0, busy=0.
- Op classification of i_alu at accept:
  - MUL* -> cnt=LAT_MUL, sel_x=1.
  - FADD/FSUB -> cnt=LAT_FADD, sel_x=0.
  - DIV/DIVU/REM/REMU/FDIV -> cnt=LAT_DIV, sel_x=0.
  - All other ops -> cnt=0, sel_x=0.
- i_ready (combinational) = !flush && (state==IDLE || (state==EX && cnt==0)).
- On accept at edge T:
  - alu/rrd1/rrd2, the rd tag, sel_x and cnt are registered.
  - state <= EX.
- State EX:
  - alu/rrd1/rrd2 are held stable.
  - cnt decrements by 1 per cycle while cnt!=0.
  - When cnt==0 the final cycle is reached: o_data <= sel_x ? rwdatx : rwdat, o_rd <= tag, o_valid <= 1 for exactly one cycle.
  - In the final cycle, state <= EX if a new op is accepted in that same cycle (back-to-back), else IDLE.
- Latency from accept edge T to the o_valid cycle:
  - single: T+2.
  - MUL: T+3.
  - FADD/FSUB: T+3.
  - DIV class: T+18 with defaults.
  - Single-cycle ops sustain 1 op/cycle throughput.
- flush:
  - In EX: state <= IDLE, cnt <= 0, no o_valid for the cancelled op.
  - An o_valid already registered the previous cycle still completes.
  - In IDLE: no effect except forcing i_ready=0.
  - flush and i_valid in the same cycle: the op is not accepted.
- o_valid is asserted for rd=0 too; the writeback stage discards it.
- There is no output backpressure; the consumer must accept every o_valid.
- stall_cnt increments when i_valid && !i_ready (this includes flush cycles) and saturates at 0xFFFF_FFFF.
- Reset asserted mid-operation aborts immediately to the reset values; nothing is emitted.
- i_alu/i_rs1/i_rs2/i_rd are sampled only on accept; changes while i_ready=0 are ignored.

Test Plan:
- Back-to-back single ops: ADD 3,4 rd=5, then SUB 10,3 rd=6 on consecutive cycles -> o_valid on two consecutive cycles with (5,7) then (6,7); i_ready stays 1; stall_cnt=0.
- MUL class: MUL 0x10000 * 0x10000 rd=7 -> o_valid at T+3 with o_data=rwdatx=0; a following ADD held valid is accepted at T+2, and stall_cnt increments by 1.
- DIV latency: DIVU 100,7 rd=9 -> busy for 17 cycles, o_valid at T+18 with o_data=14; stall_cnt=16 when i_valid is held high from T+1.
- Flush mid-DIV: REM 100,7 accepted, flush at T+5 -> no o_valid; IDLE at T+6; next ADD 1,1 gives o_valid with data 2 two cycles after its accept.
- Flush with simultaneous issue: i_valid=1 and flush=1 in IDLE -> not accepted; stall_cnt+1; accepted the next cycle once flush=0.
- Reset mid-FADD: xreset low at T+1 -> o_valid never asserted, all outputs at reset values asynchronously; normal issue resumes after release.
